// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle control FSM:
//   - state_t   : FSM state encoding (also exposed on the debug state port)
//   - OP_*      : instruction opcodes (IR[31:26]) understood by the controller
//   - ALUOP_*   : encodings expected by the downstream ALU-control decoder
//   - PCSRC_* / ALUSRCB_* : datapath mux select encodings
//   - ctrl_t    : bundle of all control outputs
//   - decode_next() : DECODE-state dispatch; FETCH marks an unsupported opcode
// ----------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_IMMEX    = 4'd9,
        S_IMMWB    = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALUOP_RTYPE = 4'b0000;
    localparam logic [3:0] ALUOP_BEQ   = 4'b0100;
    localparam logic [3:0] ALUOP_BNE   = 4'b0101;
    localparam logic [3:0] ALUOP_ADD   = 4'b1000;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUSRCB_REG   = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       alu_src_a;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] pc_src;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
    } ctrl_t;

    // Every supported opcode leaves DECODE for a non-FETCH state, so a
    // FETCH result doubles as the "unsupported opcode" indication.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_LW, OP_SW:                  nxt = S_MEMADR;
            OP_RTYPE:                      nxt = S_EXEC;
            OP_BEQ, OP_BNE:                nxt = S_BRANCH;
            OP_ADDI, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI:      nxt = S_IMMEX;
            OP_J:                          nxt = S_JUMP;
            default:                       nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ctrl_fsm_out.sv
// ----------------------------------------------------------------------------
// ctrl_fsm_out
// Combinational output decoder of the control FSM (Moore, except FETCH
// gating IRWrite/PCWrite on mem_ready).
// Ports:
//   i_state     : current FSM state
//   i_op_q      : opcode latched in DECODE
//   i_mem_ready : memory handshake
//   o_ctrl      : full control-signal bundle
// ----------------------------------------------------------------------------
module ctrl_fsm_out
    import ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_op_q,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    // Map state / latched opcode to control signals; all-zero with ALU add as base.
    always_comb begin
        o_ctrl        = '0;
        o_ctrl.alu_op = ALUOP_ADD;
        case (i_state)
            S_FETCH: begin
                o_ctrl.alu_src_b = ALUSRCB_FOUR;
                o_ctrl.pc_src    = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded.
                o_ctrl.alu_src_b = ALUSRCB_IMMSH;
            end
            S_MEMADR: begin
                // Address add is fixed: sw[3:0] would alias the sltiu ALUOp.
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUSRCB_IMM;
            end
            S_MEMREAD: begin
                o_ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUSRCB_REG;
                o_ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_ALUWB: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUSRCB_REG;
                o_ctrl.pc_src    = PCSRC_ALUOUT;
                if (i_op_q == OP_BNE) begin
                    o_ctrl.alu_op    = ALUOP_BNE;
                    o_ctrl.branch_ne = 1'b1;
                end else if (i_op_q == OP_BEQ) begin
                    o_ctrl.alu_op = ALUOP_BEQ;
                    o_ctrl.branch = 1'b1;
                end else begin
                    o_ctrl.alu_op = ALUOP_ADD;
                end
            end
            S_IMMEX: begin
                // Immediate opcodes carry their ALU operation in the low nibble.
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUSRCB_IMM;
                o_ctrl.alu_op    = i_op_q[3:0];
            end
            S_IMMWB: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_src   = PCSRC_JUMP;
                o_ctrl.pc_write = 1'b1;
            end
            default: begin
                o_ctrl.alu_op = ALUOP_ADD;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// ----------------------------------------------------------------------------
// ctrl_fsm
// Multi-cycle processor control FSM. Holds the state register, the opcode
// latched in DECODE (op_q) and a sticky illegal-opcode flag; output decode
// lives in ctrl_fsm_out.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   opcode[5:0]      : IR[31:26], valid from DECODE onward
//   mem_ready        : memory access completes in the cycle it is high
//   IorD .. RegWrite : 1-bit datapath controls
//   PCSrc, ALUSrcB   : 2-bit mux selects
//   ALUOp[3:0]       : ALU-control decoder operation
//   illegal          : sticky unsupported-opcode flag
//   state[3:0]       : current state for debug
// ----------------------------------------------------------------------------
module ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       BranchNe,
    output logic       ALUSrcA,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next;
    state_t     w_dec_next;
    logic [5:0] r_op_q;
    logic       r_illegal;
    ctrl_t      w_ctrl;

    assign w_dec_next = decode_next(opcode);

    // Next-state logic; unknown encodings recover to FETCH.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   w_next = w_dec_next;
            S_MEMADR: begin
                if (r_op_q == OP_LW) begin
                    w_next = S_MEMREAD;
                end else if (r_op_q == OP_SW) begin
                    w_next = S_MEMWRITE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXEC:     w_next = S_ALUWB;
            S_IMMEX:    w_next = S_IMMWB;
            S_MEMWB,
            S_ALUWB,
            S_IMMWB,
            S_BRANCH,
            S_JUMP:     w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    // State register, opcode latch and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_op_q    <= 6'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op_q <= opcode;
                if (w_dec_next == S_FETCH) begin
                    r_illegal <= 1'b1;
                end
            end
        end
    end

    ctrl_fsm_out u_out (
        .i_state     (r_state),
        .i_op_q      (r_op_q),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // Write enables are forced low while reset is held, so a reset asserted
    // mid-access never leaves a stray write strobe active.
    assign IorD     = w_ctrl.iord;
    assign MemWrite = w_ctrl.mem_write & rst_n;
    assign IRWrite  = w_ctrl.ir_write  & rst_n;
    assign PCWrite  = w_ctrl.pc_write  & rst_n;
    assign Branch   = w_ctrl.branch;
    assign BranchNe = w_ctrl.branch_ne;
    assign ALUSrcA  = w_ctrl.alu_src_a;
    assign RegDst   = w_ctrl.reg_dst;
    assign MemtoReg = w_ctrl.mem_to_reg;
    assign RegWrite = w_ctrl.reg_write & rst_n;
    assign PCSrc    = w_ctrl.pc_src;
    assign ALUSrcB  = w_ctrl.alu_src_b;
    assign ALUOp    = w_ctrl.alu_op;
    assign illegal  = r_illegal;
    assign state    = r_state;

endmodule

// File: tb/tb_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_ctrl_fsm
// Directed bench for ctrl_fsm: each cycle drives mem_ready/opcode at the
// falling edge, then compares state and the packed control word against
// hand-written expected values.
// ----------------------------------------------------------------------------
module tb_ctrl_fsm;
    import ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       IorD, MemWrite, IRWrite, PCWrite, Branch, BranchNe;
    logic       ALUSrcA, RegDst, MemtoReg, RegWrite;
    logic [1:0] PCSrc, ALUSrcB;
    logic [3:0] ALUOp;
    logic       illegal;
    logic [3:0] state;

    int total_cnt = 0;
    int bad_cnt   = 0;

    ctrl_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .IorD      (IorD),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .Branch    (Branch),
        .BranchNe  (BranchNe),
        .ALUSrcA   (ALUSrcA),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .PCSrc     (PCSrc),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .illegal   (illegal),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] obs_word;
    assign obs_word = {IorD, MemWrite, IRWrite, PCWrite, Branch, BranchNe,
                       ALUSrcA, RegDst, MemtoReg, RegWrite, PCSrc, ALUSrcB, ALUOp};

    // Assemble an expected control word from individually written fields.
    function automatic logic [17:0] cw(
        input logic iord, input logic memw, input logic irw, input logic pcw,
        input logic br, input logic brne, input logic asa, input logic rdst,
        input logic m2r, input logic rw, input logic [1:0] pcsrc,
        input logic [1:0] asb, input logic [3:0] aluop);
        return {iord, memw, irw, pcw, br, brne, asa, rdst, m2r, rw, pcsrc, asb, aluop};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, then check state and word.
    task automatic cyc(input string tag, input logic mr, input logic [5:0] opc,
                       input state_t est, input logic [17:0] ew);
        @(negedge clk);
        mem_ready = mr;
        opcode    = opc;
        #1;
        check_val({tag, "_st"}, {28'd0, state}, {28'd0, est});
        check_val({tag, "_cw"}, {14'd0, obs_word}, {14'd0, ew});
    endtask

    // Expected words, written out per state.
    logic [17:0] W_FETCH_IDLE, W_FETCH_RDY, W_DECODE, W_MEMADR, W_MEMREAD, W_MEMWB;
    logic [17:0] W_MEMWRITE, W_EXEC, W_ALUWB, W_SLTIU, W_XORI, W_IMMWB;
    logic [17:0] W_BNE, W_BEQ, W_JUMP, W_MEMWRITE_RST;

    initial begin
        W_FETCH_IDLE   = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,4'b1000);
        W_FETCH_RDY    = cw(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,4'b1000);
        W_DECODE       = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,4'b1000);
        W_MEMADR       = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b10,4'b1000);
        W_MEMREAD      = cw(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,4'b1000);
        W_MEMWB        = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,4'b1000);
        W_MEMWRITE     = cw(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,4'b1000);
        W_MEMWRITE_RST = cw(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,4'b1000);
        W_EXEC         = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,4'b0000);
        W_ALUWB        = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,4'b1000);
        W_SLTIU        = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b10,4'b1011);
        W_XORI         = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b10,4'b1110);
        W_IMMWB        = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,4'b1000);
        W_BNE          = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b01,2'b00,4'b0101);
        W_BEQ          = cw(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,2'b00,4'b0100);
        W_JUMP         = cw(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,4'b1000);

        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        // Reset held with mem_ready high: FETCH, but no write strobes.
        check_val("rst_st",  {28'd0, state}, {28'd0, S_FETCH});
        check_val("rst_cw",  {14'd0, obs_word}, {14'd0, W_FETCH_IDLE});
        check_val("rst_ill", {31'd0, illegal}, 32'd0);
        rst_n     = 1'b1;
        mem_ready = 1'b0;

        // FETCH holds while memory is not ready.
        cyc("hold0", 1'b0, 6'b000000, S_FETCH, W_FETCH_IDLE);

        // lw: 5 cycles; opcode input scrambled after DECODE to prove op_q use.
        cyc("lw_f",  1'b1, 6'b000000, S_FETCH,   W_FETCH_RDY);
        cyc("lw_d",  1'b1, 6'b100011, S_DECODE,  W_DECODE);
        cyc("lw_a",  1'b1, 6'b101011, S_MEMADR,  W_MEMADR);
        cyc("lw_r",  1'b1, 6'b000000, S_MEMREAD, W_MEMREAD);
        cyc("lw_wb", 1'b1, 6'b000000, S_MEMWB,   W_MEMWB);

        // sw with three wait cycles in MEMWRITE.
        cyc("sw_f",  1'b1, 6'b000000, S_FETCH,    W_FETCH_RDY);
        cyc("sw_d",  1'b1, 6'b101011, S_DECODE,   W_DECODE);
        cyc("sw_a",  1'b0, 6'b100011, S_MEMADR,   W_MEMADR);
        cyc("sw_w0", 1'b0, 6'b000000, S_MEMWRITE, W_MEMWRITE);
        cyc("sw_w1", 1'b0, 6'b000000, S_MEMWRITE, W_MEMWRITE);
        cyc("sw_w2", 1'b0, 6'b000000, S_MEMWRITE, W_MEMWRITE);
        cyc("sw_w3", 1'b1, 6'b000000, S_MEMWRITE, W_MEMWRITE);

        // R-type.
        cyc("r_f",  1'b1, 6'b111111, S_FETCH, W_FETCH_RDY);
        cyc("r_d",  1'b1, 6'b000000, S_DECODE, W_DECODE);
        cyc("r_e",  1'b1, 6'b111111, S_EXEC,  W_EXEC);
        cyc("r_wb", 1'b1, 6'b111111, S_ALUWB, W_ALUWB);

        // sltiu and xori.
        cyc("slt_f",  1'b1, 6'b000000, S_FETCH,  W_FETCH_RDY);
        cyc("slt_d",  1'b1, 6'b001011, S_DECODE, W_DECODE);
        cyc("slt_x",  1'b1, 6'b000000, S_IMMEX,  W_SLTIU);
        cyc("slt_wb", 1'b1, 6'b000000, S_IMMWB,  W_IMMWB);
        cyc("xor_f",  1'b1, 6'b000000, S_FETCH,  W_FETCH_RDY);
        cyc("xor_d",  1'b1, 6'b001110, S_DECODE, W_DECODE);
        cyc("xor_x",  1'b1, 6'b000000, S_IMMEX,  W_XORI);
        cyc("xor_wb", 1'b1, 6'b000000, S_IMMWB,  W_IMMWB);

        // bne then beq.
        cyc("bne_f", 1'b1, 6'b000000, S_FETCH,  W_FETCH_RDY);
        cyc("bne_d", 1'b1, 6'b000101, S_DECODE, W_DECODE);
        cyc("bne_b", 1'b1, 6'b000100, S_BRANCH, W_BNE);
        cyc("beq_f", 1'b1, 6'b000000, S_FETCH,  W_FETCH_RDY);
        cyc("beq_d", 1'b1, 6'b000100, S_DECODE, W_DECODE);
        cyc("beq_b", 1'b1, 6'b000101, S_BRANCH, W_BEQ);

        // j.
        cyc("j_f", 1'b1, 6'b000000, S_FETCH,  W_FETCH_RDY);
        cyc("j_d", 1'b1, 6'b000010, S_DECODE, W_DECODE);
        cyc("j_j", 1'b1, 6'b000000, S_JUMP,   W_JUMP);
        check_val("ill_clear", {31'd0, illegal}, 32'd0);

        // Unsupported opcode: back to FETCH, illegal set and sticky.
        cyc("ill_f",  1'b1, 6'b000000, S_FETCH,  W_FETCH_RDY);
        cyc("ill_d",  1'b0, 6'b111111, S_DECODE, W_DECODE);
        cyc("ill_f2", 1'b0, 6'b000000, S_FETCH,  W_FETCH_IDLE);
        check_val("ill_set", {31'd0, illegal}, 32'd1);

        // sw interrupted by reset in MEMWRITE.
        cyc("rs_f", 1'b1, 6'b000000, S_FETCH,    W_FETCH_RDY);
        cyc("rs_d", 1'b1, 6'b101011, S_DECODE,   W_DECODE);
        cyc("rs_a", 1'b0, 6'b000000, S_MEMADR,   W_MEMADR);
        cyc("rs_w", 1'b0, 6'b000000, S_MEMWRITE, W_MEMWRITE);
        check_val("ill_sticky", {31'd0, illegal}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rs_gate_cw", {14'd0, obs_word}, {14'd0, W_MEMWRITE_RST});
        @(negedge clk);
        #1;
        check_val("rs_st",  {28'd0, state}, {28'd0, S_FETCH});
        check_val("rs_cw",  {14'd0, obs_word}, {14'd0, W_FETCH_IDLE});
        check_val("rs_ill", {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;

        // After release: FETCH values, then a normal fetch.
        cyc("post_f", 1'b1, 6'b000000, S_FETCH,  W_FETCH_RDY);
        cyc("post_d", 1'b1, 6'b000010, S_DECODE, W_DECODE);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: `clk` (in, 1) rises to sample all state; `rst_n` (in, 1) resets synchronously when low.
REQ-002 `opcode` (in, 6) SHALL be the instruction register bits [31:26], valid from the DECODE state onward.
REQ-003 `mem_ready` (in, 1) SHALL be the memory handshake; the current memory access completes in the cycle it is high.
REQ-004 The block SHALL drive these 1-bit outputs: `IorD`, `MemWrite`, `IRWrite`, `PCWrite`, `Branch`, `BranchNe`, `ALUSrcA`, `RegDst`, `MemtoReg`, `RegWrite`.
REQ-005 The block SHALL drive these 2-bit outputs: `PCSrc` (00=ALU, 01=ALUOut, 10=jump) and `ALUSrcB` (00=reg, 01=const 4, 10=sign-ext imm, 11=imm<<2).
REQ-006 `ALUOp` (out, 4) SHALL feed the downstream ALU-control decoder, using its encoding.
REQ-007 `illegal` (out, 1) SHALL be a sticky flag, set on an unsupported opcode.
REQ-008 `state` (out, 4) SHALL expose the current state for debug.

Function
REQ-009 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC, ALUWB, BRANCH, IMMEX, IMMWB, JUMP.
REQ-010 The opcode SHALL be latched into `op_q` on the DECODE cycle, and all later states SHALL decode from `op_q`.
REQ-011 DECODE transitions SHALL be:
- 100011 or 101011 -> MEMADR
- 000000 -> EXEC
- 000100 or 000101 -> BRANCH
- 001000, 001010, 001011, 001100, 001101, 001110 -> IMMEX
- 000010 -> JUMP
- any other opcode -> FETCH, setting `illegal`.
REQ-012 Other transitions SHALL be:
- MEMADR -> MEMREAD (lw) or MEMWRITE (sw)
- MEMREAD -> MEMWB on `mem_ready`
- MEMWRITE -> FETCH on `mem_ready`
- EXEC -> ALUWB
- IMMEX -> IMMWB
- MEMWB, ALUWB, IMMWB, BRANCH, JUMP -> FETCH.
REQ-013 FETCH SHALL hold until `mem_ready`, then go to DECODE; it drives IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=1000, PCSrc=00.
REQ-014 In FETCH, IRWrite=1 and PCWrite=1 SHALL be asserted only in the cycle `mem_ready`=1.
REQ-015 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=1000 (branch target).
REQ-016 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=1000; ALUOp is never derived from the lw/sw opcode, because sw[3:0] aliases sltiu.
REQ-017 MEMREAD SHALL drive IorD=1.
REQ-018 MEMWRITE SHALL drive IorD=1 and MemWrite=1 every cycle until `mem_ready`.
REQ-019 MEMWB SHALL drive RegDst=0, MemtoReg=1, RegWrite=1.
REQ-020 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=0000.
REQ-021 ALUWB SHALL drive RegDst=1, MemtoReg=0, RegWrite=1.
REQ-022 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, PCSrc=01, plus ALUOp=0100 and Branch=1 for beq, or ALUOp=0101 and BranchNe=1 for bne.
REQ-023 IMMEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=op_q[3:0].
REQ-024 IMMWB SHALL drive RegDst=0, MemtoReg=0, RegWrite=1.
REQ-025 JUMP SHALL drive PCSrc=10, PCWrite=1.
REQ-026 Any output not listed for a state SHALL be 0, and ALUOp SHALL default to 1000.
REQ-027 With `mem_ready` tied high, instruction cycle counts SHALL be: lw 5, sw 4, R-type 4, immediate 4, beq/bne 3, j 3.
REQ-028 Outputs SHALL be a pure function of state, `op_q` and `mem_ready` (Moore, except the `mem_ready` gating).
REQ-029 An unreachable state encoding SHALL return to FETCH on the next clock.

Reset
REQ-030 When `rst_n`=0 at a clock edge, the state SHALL become FETCH, and `op_q` and `illegal` SHALL become 0.
REQ-031 Reset SHALL take priority over every transition, including one in the middle of MEMWRITE or MEMREAD.
REQ-032 During reset, all write enables SHALL be 0 (MemWrite, IRWrite, PCWrite, RegWrite).
REQ-033 After reset is released, outputs SHALL be the FETCH values.

Structure
REQ-034 A shared package `ctrl_pkg` SHALL hold the state encoding, the opcode constants and the ALUOp constants (including ADD=1000, RTYPE=0000, BEQ=0100, BNE=0101).
REQ-035 Output generation SHALL be in one sub-module, `ctrl_fsm_out`: a combinational mapping of state, `op_q` and `mem_ready` to control signals.
REQ-036 The state register, `op_q` and `illegal` SHALL reside in `ctrl_fsm`.

Verification
REQ-037 lw (100011), `mem_ready`=1: the state sequence SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, with RegWrite=1 and MemtoReg=1 only in cycle 5.
REQ-038 sw (101011), `mem_ready` low for 3 MEMWRITE cycles: MemWrite=1 SHALL hold for 4 cycles, FETCH follows, and ALUOp=1000 in MEMADR.
REQ-039 sltiu (001011) SHALL give ALUOp=1011 in IMMEX, and xori (001110) SHALL give ALUOp=1110.
REQ-040 bne (000101) SHALL give ALUOp=0101, BranchNe=1, Branch=0, PCSrc=01 in BRANCH, then FETCH.
REQ-041 Opcode 111111 SHALL set `illegal`=1 and return to FETCH with no write enables; `illegal` stays 1 until reset.
REQ-042 `rst_n`=0 asserted in MEMWRITE with `mem_ready`=0 SHALL put the state in FETCH the next cycle with MemWrite=0.
